// File: rtl/change_dispenser.sv
// Vending change dispenser: product motor timing, coin hopper payout, jam detection.
// Optional build macro DISPENSE_TIMEOUT_EN adds a PAY no-coin timeout that forces JAM.
module change_dispenser #(
    parameter int MOTOR_CYCLES   = 8,
    parameter int GAP_CYCLES     = 2,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       vend,
    input  logic [1:0] change,
    input  logic       coin_sense,
    input  logic       hopper_empty,
    output logic       busy,
    output logic       product_motor,
    output logic       hopper_motor,
    output logic [1:0] owed,
    output logic       done,
    output logic       jam,
    output logic       lost
);

    if (MOTOR_CYCLES < 1 || MOTOR_CYCLES > 255 || GAP_CYCLES < 1 || GAP_CYCLES > 15 ||
        TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 1023) begin : g_param_check
        $error("change_dispenser: parameter out of range");
    end

    typedef enum logic [2:0] {
        S_IDLE, S_VEND, S_PAY, S_GAP, S_DONE, S_JAM
    } state_t;

    localparam logic [7:0] MOTOR_LOAD = 8'(MOTOR_CYCLES - 1);
    localparam logic [7:0] GAP_LOAD   = 8'(GAP_CYCLES - 1);

    state_t     state, state_nx;
    logic [7:0] cnt, cnt_nx;
    logic [1:0] owed_nx;
    logic       lost_nx;
    logic       coin_s1, coin_s2, coin_s3;
    logic       coin_edge;
    logic       request;

`ifdef DISPENSE_TIMEOUT_EN
    localparam logic [9:0] TMO_LOAD = 10'(TIMEOUT_CYCLES - 1);
    logic [9:0] tmo, tmo_nx;
`endif

    assign request   = vend || (change != 2'b00);
    assign coin_edge = coin_s2 && !coin_s3;

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        owed_nx  = owed;
        lost_nx  = lost;
`ifdef DISPENSE_TIMEOUT_EN
        tmo_nx   = tmo;
`endif
        if (request && state != S_IDLE)
            lost_nx = 1'b1;

        case (state)
            S_IDLE: begin
                if (request) begin
                    owed_nx = change;
                    if (vend) begin
                        state_nx = S_VEND;
                        cnt_nx   = MOTOR_LOAD;
                    end else begin
                        state_nx = S_PAY;
                    end
                end
            end
            S_VEND: begin
                if (cnt == 8'd0)
                    state_nx = (owed != 2'b00) ? S_PAY : S_DONE;
                else
                    cnt_nx = cnt - 8'd1;
            end
            S_PAY: begin
                // An empty hopper outranks a coin arriving in the same cycle.
                if (hopper_empty) begin
                    state_nx = S_JAM;
                end else if (coin_edge) begin
                    if (owed <= 2'd1) begin
                        owed_nx  = 2'd0;
                        state_nx = S_DONE;
                    end else begin
                        owed_nx  = owed - 2'd1;
                        state_nx = S_GAP;
                        cnt_nx   = GAP_LOAD;
                    end
                end
`ifdef DISPENSE_TIMEOUT_EN
                else if (tmo == 10'd0)
                    state_nx = S_JAM;
                else
                    tmo_nx = tmo - 10'd1;
`endif
            end
            S_GAP: begin
                if (hopper_empty)
                    state_nx = S_JAM;
                else if (cnt == 8'd0)
                    state_nx = S_PAY;
                else
                    cnt_nx = cnt - 8'd1;
            end
            S_DONE: begin
                state_nx = S_IDLE;
                owed_nx  = 2'd0;
            end
            S_JAM:   state_nx = S_JAM;
            default: state_nx = S_IDLE;
        endcase

`ifdef DISPENSE_TIMEOUT_EN
        if (state_nx == S_PAY && state != S_PAY)
            tmo_nx = TMO_LOAD;
`endif
    end

    // Outputs are registered from the next state so they change with the state flop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= S_IDLE;
            cnt           <= 8'd0;
            owed          <= 2'd0;
            lost          <= 1'b0;
            coin_s1       <= 1'b0;
            coin_s2       <= 1'b0;
            coin_s3       <= 1'b0;
            busy          <= 1'b0;
            product_motor <= 1'b0;
            hopper_motor  <= 1'b0;
            done          <= 1'b0;
            jam           <= 1'b0;
`ifdef DISPENSE_TIMEOUT_EN
            tmo           <= 10'd0;
`endif
        end else begin
            state         <= state_nx;
            cnt           <= cnt_nx;
            owed          <= owed_nx;
            lost          <= lost_nx;
            coin_s1       <= coin_sense;
            coin_s2       <= coin_s1;
            coin_s3       <= coin_s2;
            busy          <= (state_nx != S_IDLE);
            product_motor <= (state_nx == S_VEND);
            hopper_motor  <= (state_nx == S_PAY);
            done          <= (state_nx == S_DONE);
            jam           <= (state_nx == S_JAM);
`ifdef DISPENSE_TIMEOUT_EN
            tmo           <= tmo_nx;
`endif
        end
    end

endmodule

// File: tb/tb_change_dispenser.sv
// Self-checking bench for change_dispenser; owed decrements are tracked through a scoreboard queue.
module tb_change_dispenser;

    logic       clk = 1'b0;
    logic       rst;
    logic       vend;
    logic [1:0] change;
    logic       coin_sense;
    logic       hopper_empty;
    logic       busy, product_motor, hopper_motor, done, jam, lost;
    logic [1:0] owed;

    int checks = 0;
    int errors = 0;
    logic [1:0] exp_owed[$];

    // {busy, product_motor, hopper_motor, owed[1:0], done, jam, lost}
    wire [7:0] outs = {busy, product_motor, hopper_motor, owed, done, jam, lost};

    change_dispenser dut (
        .clk(clk), .rst(rst), .vend(vend), .change(change),
        .coin_sense(coin_sense), .hopper_empty(hopper_empty),
        .busy(busy), .product_motor(product_motor), .hopper_motor(hopper_motor),
        .owed(owed), .done(done), .jam(jam), .lost(lost)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(negedge clk);
    endtask

    // Drives a 2-cycle coin pulse and returns how many cycles until owed moved (-1: never).
    task automatic coin_and_wait(output int lat);
        logic [1:0] prev;
        prev = owed;
        lat = -1;
        coin_sense = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            tick();
            if (i == 2) coin_sense = 1'b0;
            if (owed !== prev) begin
                lat = i;
                break;
            end
        end
        coin_sense = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; vend = 1'b0; change = 2'b00; coin_sense = 1'b0; hopper_empty = 1'b0;
        tick(); tick();
        checks++;
        if (outs !== 8'h00) begin
            errors++; $display("FAIL reset_outs: got %b expected %b", outs, 8'h00);
        end
        rst = 1'b0;
        tick();
        checks++;
        if (outs !== 8'h00) begin
            errors++; $display("FAIL idle_after_reset: got %b expected %b", outs, 8'h00);
        end
    endtask

    task automatic test_vend_only();
        int pm_cnt = 0, hm_cnt = 0, done_cnt = 0, both = 0;
        vend = 1'b1; change = 2'b00;
        tick();
        vend = 1'b0;
        checks++;
        if (outs !== 8'b1100_0000) begin
            errors++; $display("FAIL vend_start: got %b expected %b", outs, 8'b1100_0000);
        end
        for (int i = 0; i < 40; i++) begin
            if (product_motor) pm_cnt++;
            if (hopper_motor) hm_cnt++;
            if (done) done_cnt++;
            if (product_motor && hopper_motor) both++;
            if (!busy) break;
            tick();
        end
        checks++;
        if (pm_cnt != 8) begin
            errors++; $display("FAIL vend_motor_cycles: got %0d expected 8", pm_cnt);
        end
        checks++;
        if (hm_cnt != 0 || both != 0) begin
            errors++; $display("FAIL vend_no_hopper: got %0d expected 0", hm_cnt + both);
        end
        checks++;
        if (done_cnt != 1 || busy !== 1'b0) begin
            errors++; $display("FAIL vend_done: got done=%0d busy=%b expected 1 0", done_cnt, busy);
        end
    endtask

    task automatic test_vend_change();
        int pm_cnt = 0, low = 0, lat;
        vend = 1'b1; change = 2'b10;
        tick();
        vend = 1'b0; change = 2'b00;
        checks++;
        if (outs !== 8'b1101_0000) begin
            errors++; $display("FAIL vc_start: got %b expected %b", outs, 8'b1101_0000);
        end
        for (int i = 0; i < 40; i++) begin
            if (product_motor) pm_cnt++;
            if (hopper_motor) break;
            tick();
        end
        checks++;
        if (pm_cnt != 8 || outs !== 8'b1011_0000) begin
            errors++; $display("FAIL vc_to_pay: got pm=%0d outs=%b expected 8 %b", pm_cnt, outs, 8'b1011_0000);
        end
        exp_owed.push_back(2'd1);
        coin_and_wait(lat);
        checks++;
        if (lat != 3) begin
            errors++; $display("FAIL vc_coin1_latency: got %0d expected 3", lat);
        end
        checks++;
        if (owed !== exp_owed.pop_front()) begin
            errors++; $display("FAIL vc_owed1: got %0d expected 1", owed);
        end
        for (int i = 0; i < 10; i++) begin
            if (hopper_motor) break;
            low++;
            tick();
        end
        checks++;
        if (low != 2) begin
            errors++; $display("FAIL vc_gap_len: got %0d expected 2", low);
        end
        exp_owed.push_back(2'd0);
        coin_and_wait(lat);
        checks++;
        if (lat != 3 || owed !== exp_owed.pop_front()) begin
            errors++; $display("FAIL vc_owed0: got lat=%0d owed=%0d expected 3 0", lat, owed);
        end
        checks++;
        if (outs !== 8'b1000_0100) begin
            errors++; $display("FAIL vc_done: got %b expected %b", outs, 8'b1000_0100);
        end
        tick();
        checks++;
        if (outs !== 8'h00) begin
            errors++; $display("FAIL vc_idle: got %b expected %b", outs, 8'h00);
        end
    endtask

    task automatic test_change_only();
        int lat;
        change = 2'b01;
        tick();
        change = 2'b00;
        checks++;
        if (outs !== 8'b1010_1000) begin
            errors++; $display("FAIL co_start: got %b expected %b", outs, 8'b1010_1000);
        end
        exp_owed.push_back(2'd0);
        coin_and_wait(lat);
        checks++;
        if (lat != 3 || owed !== exp_owed.pop_front() || outs !== 8'b1000_0100) begin
            errors++; $display("FAIL co_done: got lat=%0d outs=%b expected 3 %b", lat, outs, 8'b1000_0100);
        end
        tick();
        checks++;
        if (outs !== 8'h00) begin
            errors++; $display("FAIL co_idle: got %b expected %b", outs, 8'h00);
        end
    endtask

    task automatic test_idle_coin();
        int lat;
        coin_and_wait(lat);
        checks++;
        if (lat != -1 || outs !== 8'h00) begin
            errors++; $display("FAIL idle_coin_ignored: got lat=%0d outs=%b expected -1 %b", lat, outs, 8'h00);
        end
    endtask

    task automatic test_lost_gap_jam();
        int lat;
        change = 2'b11;
        tick();
        change = 2'b00;
        checks++;
        if (outs !== 8'b1011_1000) begin
            errors++; $display("FAIL lj_start: got %b expected %b", outs, 8'b1011_1000);
        end
        vend = 1'b1;
        tick();
        vend = 1'b0;
        checks++;
        if (outs !== 8'b1011_1001) begin
            errors++; $display("FAIL lj_lost: got %b expected %b", outs, 8'b1011_1001);
        end
        exp_owed.push_back(2'd2);
        coin_and_wait(lat);
        checks++;
        if (lat != 3 || owed !== exp_owed.pop_front() || outs !== 8'b1001_0001) begin
            errors++; $display("FAIL lj_gap: got lat=%0d outs=%b expected 3 %b", lat, outs, 8'b1001_0001);
        end
        hopper_empty = 1'b1;
        tick();
        hopper_empty = 1'b0;
        checks++;
        if (outs !== 8'b1001_0011) begin
            errors++; $display("FAIL lj_jam: got %b expected %b", outs, 8'b1001_0011);
        end
        coin_and_wait(lat);
        checks++;
        if (lat != -1 || outs !== 8'b1001_0011) begin
            errors++; $display("FAIL lj_jam_hold: got lat=%0d outs=%b expected -1 %b", lat, outs, 8'b1001_0011);
        end
    endtask

    task automatic test_reset_mid_pay();
        int lat;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        checks++;
        if (outs !== 8'h00) begin
            errors++; $display("FAIL rm_cleared: got %b expected %b", outs, 8'h00);
        end
        change = 2'b10;
        tick();
        change = 2'b00;
        repeat (3) tick();
        checks++;
        if (outs !== 8'b1011_0000) begin
            errors++; $display("FAIL rm_pay: got %b expected %b", outs, 8'b1011_0000);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (outs !== 8'h00) begin
            errors++; $display("FAIL rm_async: got %b expected %b", outs, 8'h00);
        end
        tick();
        rst = 1'b0;
        change = 2'b01;
        tick();
        change = 2'b00;
        checks++;
        if (outs !== 8'b1010_1000) begin
            errors++; $display("FAIL rm_accept: got %b expected %b", outs, 8'b1010_1000);
        end
        exp_owed.push_back(2'd0);
        coin_and_wait(lat);
        checks++;
        if (lat != 3 || owed !== exp_owed.pop_front() || done !== 1'b1) begin
            errors++; $display("FAIL rm_done: got lat=%0d owed=%0d done=%b expected 3 0 1", lat, owed, done);
        end
        tick();
    endtask

    task automatic test_timeout();
        change = 2'b01;
        tick();
        change = 2'b00;
`ifdef DISPENSE_TIMEOUT_EN
        begin
            int hm_cnt = 0;
            for (int i = 0; i < 200; i++) begin
                if (jam) break;
                if (hopper_motor) hm_cnt++;
                tick();
            end
            checks++;
            if (hm_cnt != 64 || outs !== 8'b1000_1010) begin
                errors++; $display("FAIL timeout_jam: got cycles=%0d outs=%b expected 64 %b", hm_cnt, outs, 8'b1000_1010);
            end
        end
`else
        repeat (200) tick();
        checks++;
        if (outs !== 8'b1010_1000) begin
            errors++; $display("FAIL no_timeout: got %b expected %b", outs, 8'b1010_1000);
        end
`endif
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        checks++;
        if (outs !== 8'h00) begin
            errors++; $display("FAIL timeout_reset: got %b expected %b", outs, 8'h00);
        end
    endtask

    initial begin
        test_reset();
        test_vend_only();
        test_vend_change();
        test_change_only();
        test_idle_coin();
        test_lost_gap_jam();
        test_reset_mid_pay();
        test_timeout();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
